adc_bridge_host: RTL and testbench



---
 rtl/adc_bridge_pkg.sv | 18 +
 rtl/adc_bridge_host_clkgen.sv | 46 ++++
 rtl/adc_bridge_host.sv | 183 ++++++++++++++++++
 tb/tb_adc_bridge_host.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_bridge_pkg.sv
// adc_bridge_host shared types and frame constants.
// Optional build macro: ADC_BRIDGE_HOST_FRAME_CHECK_EN.
package adc_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_SHIFT,
    S_CFG_LOAD,
    S_RD_LOAD,
    S_RD_SHIFT
  } state_t;

  localparam int CFG_BITS = 33;
  localparam int RES_BITS = 20;
  localparam logic [1:0] FRAME_LO = 2'b01;
  localparam logic [1:0] FRAME_HI = 2'b10;

endpackage

// File: rtl/adc_bridge_host_clkgen.sv
// Bridge shift-clock generator: one period is 2*CLK_DIV clk cycles,
// low phase first. Counter parks at zero while disabled.
module adc_bridge_host_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_bclk,
  output logic o_low_start,
  output logic o_low_last,
  output logic o_period_end
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV);
  localparam logic [CW-1:0] LOWL = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_bclk;

  always_comb begin
    w_cnt_nxt = '0;
    if (i_en && r_cnt != LAST)
      w_cnt_nxt = r_cnt + 1'b1;
  end

  // Clock is registered from the next count so the pin never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_bclk <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_bclk <= (w_cnt_nxt >= HALF);
    end
  end

  assign o_bclk       = r_bclk;
  assign o_low_start  = i_en && (r_cnt == '0);
  assign o_low_last   = i_en && (r_cnt == LOWL);
  assign o_period_end = i_en && (r_cnt == LAST);

endmodule

// File: rtl/adc_bridge_host.sv
// Host controller for the ADC bridge: config write, result read.
// Optional build macro: ADC_BRIDGE_HOST_FRAME_CHECK_EN.
module adc_bridge_host
  import adc_bridge_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cfg1_i,
  input  logic [15:0] cfg2_i,
  input  logic        cfg_sel_i,
  input  logic        cfg_start_i,
  input  logic        conv_finish_i,
  input  logic        bridge_dat_i,
  output logic        bridge_clk_o,
  output logic        bridge_dat_o,
  output logic        bridge_load_o,
  output logic [15:0] result_o,
  output logic        result_valid_o,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic        cfg_done_o,
  output logic        busy_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_cf_q;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [5:0]             r_bit;
  logic [CFG_BITS-1:0]    r_cfg_sr;
  logic [CFG_BITS-1:0]    w_cfg_nxt;
  logic [RES_BITS-1:0]    r_shreg;
  logic [15:0]            r_result;
  logic r_pend, r_ovr, r_done, r_valid, r_dat, r_load;
  logic w_pend_nxt, w_dat_nxt, w_load_nxt;
  logic w_rd_go, w_rd_end, w_rd_more, w_frame_ok;
  logic w_en, w_trig, w_accept;
  logic w_low_start, w_low_last, w_per_end;

  assign w_trig    = r_sync[SYNC_STAGES-1] & ~r_cf_q;
  assign w_en      = (r_state != S_IDLE);
  assign w_accept  = (r_state == S_IDLE) & cfg_start_i & ~r_done;
  assign w_rd_more = r_pend | w_trig;
  assign w_rd_end  = (r_state == S_RD_SHIFT) & w_per_end
                   & (r_bit == 6'(RES_BITS - 1));

  adc_bridge_host_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (w_en),
    .o_bclk       (bridge_clk_o),
    .o_low_start  (w_low_start),
    .o_low_last   (w_low_last),
    .o_period_end (w_per_end)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rd_go     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_CFG_SHIFT;
        end else if (w_rd_more) begin
          w_rd_go     = 1'b1;
          w_state_nxt = S_RD_LOAD;
        end
      end
      S_CFG_SHIFT: begin
        if (w_per_end && r_bit == 6'(CFG_BITS - 1))
          w_state_nxt = S_CFG_LOAD;
      end
      S_CFG_LOAD: begin
        if (w_per_end) begin
          w_rd_go     = w_rd_more;
          w_state_nxt = w_rd_more ? S_RD_LOAD : S_IDLE;
        end
      end
      S_RD_LOAD: begin
        if (w_per_end)
          w_state_nxt = S_RD_SHIFT;
      end
      S_RD_SHIFT: begin
        if (w_rd_end) begin
          w_rd_go     = w_rd_more;
          w_state_nxt = w_rd_more ? S_RD_LOAD : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pin values are computed for the next cycle so they move only
  // on the first cycle of a low phase.
  always_comb begin
    w_cfg_nxt = r_cfg_sr;
    if (w_accept)
      w_cfg_nxt = {cfg_sel_i, cfg2_i, cfg1_i};
    else if (r_state == S_CFG_SHIFT && w_per_end)
      w_cfg_nxt = {1'b0, r_cfg_sr[CFG_BITS-1:1]};
    w_load_nxt = (w_state_nxt == S_CFG_LOAD)
               | (w_state_nxt == S_RD_LOAD);
    w_dat_nxt  = (w_state_nxt == S_CFG_SHIFT) & w_cfg_nxt[0];
    w_pend_nxt = w_rd_go ? (r_pend & w_trig) : (r_pend | w_trig);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_cf_q   <= 1'b0;
      r_state  <= S_IDLE;
      r_bit    <= '0;
      r_cfg_sr <= '0;
      r_shreg  <= '0;
      r_result <= '0;
      r_pend   <= 1'b0;
      r_ovr    <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_dat    <= 1'b0;
      r_load   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], conv_finish_i};
      r_cf_q   <= r_sync[SYNC_STAGES-1];
      r_state  <= w_state_nxt;
      r_cfg_sr <= w_cfg_nxt;
      r_dat    <= w_dat_nxt;
      r_load   <= w_load_nxt;
      r_pend   <= w_pend_nxt;
      if (w_trig & r_pend & ~w_rd_go)
        r_ovr <= 1'b1;
      if (w_state_nxt != r_state)
        r_bit <= '0;
      else if (w_per_end)
        r_bit <= r_bit + 1'b1;
      if (r_state == S_RD_LOAD && w_low_start)
        r_shreg <= '0;
      else if (r_state == S_RD_SHIFT && w_low_last)
        r_shreg <= {bridge_dat_i, r_shreg[RES_BITS-1:1]};
      if (r_state == S_CFG_LOAD && w_per_end)
        r_done <= 1'b1;
      r_valid <= w_rd_end & w_frame_ok;
      if (w_rd_end & w_frame_ok)
        r_result <= r_shreg[17:2];
    end
  end

`ifdef ADC_BRIDGE_HOST_FRAME_CHECK_EN
  logic r_ferr;

  assign w_frame_ok = (r_shreg[1:0] == FRAME_LO)
                    & (r_shreg[RES_BITS-1:RES_BITS-2] == FRAME_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ferr <= 1'b0;
    else
      r_ferr <= w_rd_end & ~w_frame_ok;
  end

  assign frame_err_o = r_ferr;
`else
  logic w_unused_frame;

  assign w_frame_ok     = 1'b1;
  assign w_unused_frame = ^{r_shreg[1:0], r_shreg[RES_BITS-1:RES_BITS-2]};
  assign frame_err_o    = 1'b0;
`endif

  assign bridge_dat_o   = r_dat;
  assign bridge_load_o  = r_load;
  assign result_o       = r_result;
  assign result_valid_o = r_valid;
  assign overrun_o      = r_ovr;
  assign cfg_done_o     = r_done;
  assign busy_o         = w_en;

endmodule

// File: tb/tb_adc_bridge_host.sv
// Self-checking bench for adc_bridge_host with a behavioural bridge.
// Optional build macro: ADC_BRIDGE_HOST_FRAME_CHECK_EN.
module tb_adc_bridge_host;

  localparam int CD   = 2;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg1_i = '0;
  logic [15:0] cfg2_i = '0;
  logic        cfg_sel_i = 1'b0;
  logic        cfg_start_i = 1'b0;
  logic        conv_finish_i = 1'b0;
  logic        bridge_dat_i = 1'b0;
  logic        bridge_clk_o, bridge_dat_o, bridge_load_o;
  logic [15:0] result_o;
  logic        result_valid_o, frame_err_o, overrun_o;
  logic        cfg_done_o, busy_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_bridge_host #(
    .CLK_DIV     (CD),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg1_i         (cfg1_i),
    .cfg2_i         (cfg2_i),
    .cfg_sel_i      (cfg_sel_i),
    .cfg_start_i    (cfg_start_i),
    .conv_finish_i  (conv_finish_i),
    .bridge_dat_i   (bridge_dat_i),
    .bridge_clk_o   (bridge_clk_o),
    .bridge_dat_o   (bridge_dat_o),
    .bridge_load_o  (bridge_load_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .frame_err_o    (frame_err_o),
    .overrun_o      (overrun_o),
    .cfg_done_o     (cfg_done_o),
    .busy_o         (busy_o)
  );

  // Behavioural bridge: write-once 33-bit config, then 20-bit result frames.
  logic [32:0] m_cfg_sr = '0;
  logic [32:0] m_cfg = '0;
  bit          m_cfg_written = 0;
  int          m_edges = 0;
  int          m_load_edges = 0;
  logic [19:0] m_frame = '0;
  logic [15:0] m_rv;
  logic [15:0] m_res_q[$];
  bit          m_bad_next = 0;

  always @(posedge bridge_clk_o or negedge rst_n) begin
    if (!rst_n) begin
      m_cfg_sr = '0;
      m_cfg = '0;
      m_cfg_written = 0;
      m_frame = '0;
      bridge_dat_i = 1'b0;
    end else begin
      m_edges++;
      if (bridge_load_o) begin
        m_load_edges++;
        if (!m_cfg_written) begin
          m_cfg = m_cfg_sr;
          m_cfg_written = 1;
        end else begin
          m_rv = (m_res_q.size() > 0) ? m_res_q.pop_front() : 16'h0;
          m_frame = {2'b10, m_rv, 2'b01};
          if (m_bad_next) begin
            m_frame[19] = 1'b0;
            m_bad_next = 0;
          end
          bridge_dat_i = m_frame[0];
        end
      end else if (!m_cfg_written) begin
        m_cfg_sr = {bridge_dat_o, m_cfg_sr[32:1]};
      end else begin
        m_frame = m_frame >> 1;
        bridge_dat_i = m_frame[0];
      end
    end
  end

  // Event log sampled on the falling clk edge.
  int          mv_cyc[$];
  logic [15:0] mv_res[$];
  int          mf_cyc[$];
  int          ml_cyc[$];
  logic        p_load = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (result_valid_o) begin
        mv_cyc.push_back(cyc);
        mv_res.push_back(result_o);
      end
      if (frame_err_o) mf_cyc.push_back(cyc);
      if (bridge_load_o && !p_load) ml_cyc.push_back(cyc);
    end
    p_load = bridge_load_o;
  end

  logic [15:0] last_good = '0;

  task automatic clear_log();
    mv_cyc.delete();
    mv_res.delete();
    mf_cyc.delete();
    ml_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_start_i = 1'b0;
    conv_finish_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_cfg(input logic [15:0] c1, input logic [15:0] c2,
                        input logic s, output int acc);
    cfg1_i = c1;
    cfg2_i = c2;
    cfg_sel_i = s;
    cfg_start_i = 1'b1;
    @(negedge clk);
    cfg_start_i = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(input int acc, output int lat);
    for (int i = 0; i < 400 && !cfg_done_o; i++) @(negedge clk);
    lat = cfg_done_o ? (cyc - acc) : -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bridge_clk_o, bridge_dat_o, bridge_load_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pins got=%b exp=000",
               {bridge_clk_o, bridge_dat_o, bridge_load_o});
    end
    checks++;
    if (result_o !== 16'h0) begin
      failures++;
      $display("FAIL reset_result got=%h exp=0000", result_o);
    end
    checks++;
    if ({result_valid_o, frame_err_o, overrun_o, cfg_done_o, busy_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
               {result_valid_o, frame_err_o, overrun_o, cfg_done_o, busy_o});
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || bridge_clk_o !== 1'b0 || m_edges != 0) begin
      failures++;
      $display("FAIL idle_quiet busy=%b bclk=%b edges=%0d exp=0/0/0",
               busy_o, bridge_clk_o, m_edges);
    end
  endtask

  task automatic test_config();
    int e0, l0, acc, lat;
    logic [32:0] exp_cfg;
    e0 = m_edges;
    l0 = m_load_edges;
    exp_cfg = {1'b1, 16'h1234, 16'hA5C3};
    do_cfg(16'hA5C3, 16'h1234, 1'b1, acc);
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL cfg_busy got=%b exp=1", busy_o);
    end
    wait_done(acc, lat);
    checks++;
    if (lat != 68 * CD) begin
      failures++;
      $display("FAIL cfg_latency got=%0d exp=%0d", lat, 68 * CD);
    end
    checks++;
    if (m_cfg !== exp_cfg) begin
      failures++;
      $display("FAIL cfg_value got=%h exp=%h", m_cfg, exp_cfg);
    end
    checks++;
    if (m_load_edges - l0 != 1 || m_edges - e0 != 34) begin
      failures++;
      $display("FAIL cfg_edges got=%0d/%0d exp=1/34",
               m_load_edges - l0, m_edges - e0);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || bridge_load_o !== 1'b0) begin
      failures++;
      $display("FAIL cfg_idle busy=%b load=%b exp=0/0", busy_o, bridge_load_o);
    end
  endtask

  task automatic test_read(input logic [15:0] val);
    int t0;
    clear_log();
    m_res_q.push_back(val);
    conv_finish_i = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 300 && mv_cyc.size() == 0 && mf_cyc.size() == 0; i++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    conv_finish_i = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (mv_cyc.size() != 1 || mf_cyc.size() != 0) begin
      failures++;
      $display("FAIL read_pulses val=%h valid=%0d ferr=%0d exp=1/0",
               val, mv_cyc.size(), mf_cyc.size());
    end else begin
      checks++;
      if (ml_cyc.size() < 1 || ml_cyc[0] - t0 != SYNC + 1) begin
        failures++;
        $display("FAIL read_trig_lat got=%0d exp=%0d",
                 (ml_cyc.size() > 0) ? ml_cyc[0] - t0 : -1, SYNC + 1);
      end
      checks++;
      if (ml_cyc.size() < 1 || mv_cyc[0] - ml_cyc[0] != 42 * CD) begin
        failures++;
        $display("FAIL read_lat got=%0d exp=%0d",
                 (ml_cyc.size() > 0) ? mv_cyc[0] - ml_cyc[0] : -1, 42 * CD);
      end
      checks++;
      if (mv_res[0] !== val || result_o !== val) begin
        failures++;
        $display("FAIL read_value got=%h/%h exp=%h", mv_res[0], result_o, val);
      end
      last_good = val;
    end
  endtask

  task automatic test_frame_err();
    logic [15:0] v;
    clear_log();
    v = 16'($urandom_range(0, 65535));
    m_res_q.push_back(v);
    m_bad_next = 1;
    conv_finish_i = 1'b1;
    for (int i = 0; i < 300 && mv_cyc.size() == 0 && mf_cyc.size() == 0; i++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    conv_finish_i = 1'b0;
    repeat (4) @(negedge clk);
`ifdef ADC_BRIDGE_HOST_FRAME_CHECK_EN
    checks++;
    if (mf_cyc.size() != 1 || mv_cyc.size() != 0) begin
      failures++;
      $display("FAIL ferr_pulses ferr=%0d valid=%0d exp=1/0",
               mf_cyc.size(), mv_cyc.size());
    end
    checks++;
    if (result_o !== last_good) begin
      failures++;
      $display("FAIL ferr_hold got=%h exp=%h", result_o, last_good);
    end
`else
    checks++;
    if (mv_cyc.size() != 1 || mf_cyc.size() != 0) begin
      failures++;
      $display("FAIL nochk_pulses valid=%0d ferr=%0d exp=1/0",
               mv_cyc.size(), mf_cyc.size());
    end
    checks++;
    if (result_o !== v) begin
      failures++;
      $display("FAIL nochk_value got=%h exp=%h", result_o, v);
    end
    last_good = v;
`endif
  endtask

  task automatic test_back_to_back();
    logic [15:0] v1, v2;
    clear_log();
    v1 = 16'($urandom_range(0, 65535));
    v2 = 16'($urandom_range(0, 65535));
    m_res_q.push_back(v1);
    m_res_q.push_back(v2);
    checks++;
    if (overrun_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ovr_pre got=%b exp=0", overrun_o);
    end
    for (int k = 0; k < 3; k++) begin
      conv_finish_i = 1'b1;
      repeat (5) @(negedge clk);
      conv_finish_i = 1'b0;
      repeat (5) @(negedge clk);
    end
    for (int i = 0; i < 400 && mv_cyc.size() < 2; i++) @(negedge clk);
    repeat (150) @(negedge clk);
    checks++;
    if (mv_cyc.size() != 2 || ml_cyc.size() != 2) begin
      failures++;
      $display("FAIL b2b_count valid=%0d loads=%0d exp=2/2",
               mv_cyc.size(), ml_cyc.size());
    end else begin
      checks++;
      if (mv_res[0] !== v1 || mv_res[1] !== v2) begin
        failures++;
        $display("FAIL b2b_values got=%h,%h exp=%h,%h",
                 mv_res[0], mv_res[1], v1, v2);
      end
      checks++;
      if (mv_cyc[1] - mv_cyc[0] != 42 * CD) begin
        failures++;
        $display("FAIL b2b_gap got=%0d exp=%0d",
                 mv_cyc[1] - mv_cyc[0], 42 * CD);
      end
      last_good = v2;
    end
    checks++;
    if (overrun_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ovr ovr=%b busy=%b exp=1/0", overrun_o, busy_o);
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] c1, c2, v;
    logic        s;
    logic [32:0] exp_cfg;
    int acc, dl, e0;
    do_reset();
    clear_log();
    c1 = 16'($urandom_range(0, 65535));
    c2 = 16'($urandom_range(0, 65535));
    s  = 1'($urandom_range(0, 1));
    v  = 16'($urandom_range(0, 65535));
    exp_cfg = {s, c2, c1};
    m_res_q.push_back(v);
    conv_finish_i = 1'b1;
    repeat (2) @(negedge clk);
    do_cfg(c1, c2, s, acc);
    dl = -1;
    for (int i = 0; i < 400 && mv_cyc.size() == 0; i++) begin
      if (cfg_done_o && dl < 0) dl = cyc - acc;
      @(negedge clk);
    end
    conv_finish_i = 1'b0;
    checks++;
    if (dl != 68 * CD) begin
      failures++;
      $display("FAIL sim_cfg_lat got=%0d exp=%0d", dl, 68 * CD);
    end
    checks++;
    if (m_cfg !== exp_cfg) begin
      failures++;
      $display("FAIL sim_cfg_value got=%h exp=%h", m_cfg, exp_cfg);
    end
    checks++;
    if (mv_cyc.size() != 1) begin
      failures++;
      $display("FAIL sim_read_count got=%0d exp=1", mv_cyc.size());
    end else begin
      checks++;
      if (mv_cyc[0] - acc != 68 * CD + 42 * CD || mv_res[0] !== v) begin
        failures++;
        $display("FAIL sim_read got=%0d/%h exp=%0d/%h",
                 mv_cyc[0] - acc, mv_res[0], 68 * CD + 42 * CD, v);
      end
    end
    repeat (4) @(negedge clk);
    e0 = m_edges;
    do_cfg(~c1, ~c2, ~s, acc);
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL recfg_busy got=%b exp=0", busy_o);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (m_edges != e0 || m_cfg !== exp_cfg) begin
      failures++;
      $display("FAIL recfg_ignored edges=%0d cfg=%h exp=0/%h",
               m_edges - e0, m_cfg, exp_cfg);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] c1, c2;
    logic        s;
    int acc, lat, e0;
    do_reset();
    e0 = m_edges;
    do_cfg(16'hFFFF, 16'hFFFF, 1'b1, acc);
    for (int i = 0; i < 200 && m_edges - e0 < 10; i++) @(negedge clk);
    for (int i = 0; i < 10 && bridge_clk_o; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bridge_clk_o, bridge_dat_o, bridge_load_o, result_valid_o, frame_err_o,
         overrun_o, cfg_done_o, busy_o} !== 8'h00 || result_o !== 16'h0) begin
      failures++;
      $display("FAIL midrst_outputs got=%b/%h exp=0",
               {bridge_clk_o, bridge_dat_o, bridge_load_o, result_valid_o,
                frame_err_o, overrun_o, cfg_done_o, busy_o}, result_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    c1 = 16'($urandom_range(0, 65535));
    c2 = 16'($urandom_range(0, 65535));
    s  = 1'($urandom_range(0, 1));
    do_cfg(c1, c2, s, acc);
    wait_done(acc, lat);
    checks++;
    if (lat != 68 * CD || m_cfg !== {s, c2, c1}) begin
      failures++;
      $display("FAIL midrst_recfg lat=%0d cfg=%h exp=%0d/%h",
               lat, m_cfg, 68 * CD, {s, c2, c1});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_config();
    test_read(16'hBEEF);
    test_frame_err();
    for (int i = 0; i < 3; i++)
      test_read(16'($urandom_range(0, 65535)));
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
